// File: rtl/fixed_point_pkg.sv
// Shared Q-format defaults, FSM state type and rounding helper for the
// sequential fixed-point multiplier and divider.
package fixed_point_pkg;

    localparam int DATA_WIDTH_DEFAULT     = 32;
    localparam int QUANTIZED_BITS_DEFAULT = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Half an LSB of the result, added before the arithmetic shift (round-half-up).
    function automatic logic [63:0] round_const(input int unsigned qbits);
        round_const = 64'd1 << (qbits - 1);
    endfunction

endpackage

// File: rtl/fixed_multiply_seq_if.sv
// Request/result bus of the sequential fixed-point multiplier.
interface fixed_multiply_seq_if #(
    parameter int DATA_WIDTH = fixed_point_pkg::DATA_WIDTH_DEFAULT
);

    logic [DATA_WIDTH-1:0] multiplicand;
    logic [DATA_WIDTH-1:0] multiplier;
    logic                  valid_in;
    logic                  ready;
    logic [DATA_WIDTH-1:0] product;
    logic                  overflow;
    logic                  valid_out;

    // A request is taken on a rising edge where valid_in && ready; operands are
    // sampled on that edge only. valid_out is a one-cycle pulse with no back-pressure;
    // product/overflow hold their value until the next pulse.
    modport master (
        output multiplicand, multiplier, valid_in,
        input  ready, product, overflow, valid_out
    );

    modport slave (
        input  multiplicand, multiplier, valid_in,
        output ready, product, overflow, valid_out
    );

endinterface

// File: rtl/fixed_round_sat.sv
// Rounds a full 2*DATA_WIDTH Q-format product back to DATA_WIDTH bits and flags
// overflow; FIXED_MULTIPLY_SAT_EN selects clamping, otherwise the result wraps.
module fixed_round_sat
    import fixed_point_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
    parameter int QUANTIZED_BITS = QUANTIZED_BITS_DEFAULT
) (
    input  logic [2*DATA_WIDTH-1:0] full_product,
    output logic [DATA_WIDTH-1:0]   result,
    output logic                    overflow
);

    localparam int RW = 2 * DATA_WIDTH + 1;

    logic signed [RW-1:0]         p_ext;
    logic signed [RW-1:0]         rounded;
    logic signed [RW-1:0]         r;
    logic [RW-DATA_WIDTH:0]       hi;

    always_comb begin
        p_ext   = {full_product[2*DATA_WIDTH-1], full_product};
        rounded = p_ext + $signed(RW'(round_const(QUANTIZED_BITS)));
        r       = rounded >>> QUANTIZED_BITS;
        // Fits only if every bit from the result sign upward matches.
        hi       = r[RW-1:DATA_WIDTH-1];
        overflow = !((&hi) || !(|hi));
`ifdef FIXED_MULTIPLY_SAT_EN
        if (overflow) begin
            result = r[RW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                             : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            result = r[DATA_WIDTH-1:0];
        end
`else
        result = r[DATA_WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/fixed_multiply_seq.sv
// Iterative radix-2 Booth signed fixed-point multiplier, one step per clock.
// Build option FIXED_MULTIPLY_SAT_EN clamps overflowing results instead of wrapping.
module fixed_multiply_seq
    import fixed_point_pkg::*;
#(
    parameter int QUANTIZED_BITS = QUANTIZED_BITS_DEFAULT,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    fixed_multiply_seq_if.slave  bus,
    output state_e               dbg_state
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH:0]   m_q, m_d;
    logic [DATA_WIDTH:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic                  qm1_q, qm1_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] product_q, product_d;
    logic                  overflow_q, overflow_d;
    logic                  valid_out_q, valid_out_d;

    logic [DATA_WIDTH:0]   a_sum;
    logic [DATA_WIDTH-1:0] round_result;
    logic                  round_ovf;

    fixed_round_sat #(
        .DATA_WIDTH     (DATA_WIDTH),
        .QUANTIZED_BITS (QUANTIZED_BITS)
    ) u_round (
        .full_product (({a_q[DATA_WIDTH-1:0], q_q})),
        .result       (round_result),
        .overflow     (round_ovf)
    );

    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        a_d         = a_q;
        q_d         = q_q;
        qm1_d       = qm1_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        overflow_d  = overflow_q;
        valid_out_d = 1'b0;
        a_sum       = a_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.valid_in) begin
                    m_d     = {bus.multiplicand[DATA_WIDTH-1], bus.multiplicand};
                    a_d     = '0;
                    q_d     = bus.multiplier;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                case ({q_q[0], qm1_q})
                    2'b01:   a_sum = a_q + m_q;
                    2'b10:   a_sum = a_q - m_q;
                    default: a_sum = a_q;
                endcase
                // Arithmetic shift of the concatenation {A, Q, Q_-1}.
                a_d   = {a_sum[DATA_WIDTH], a_sum[DATA_WIDTH:1]};
                q_d   = {a_sum[0], q_q[DATA_WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                product_d   = round_result;
                overflow_d  = round_ovf;
                valid_out_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            m_q         <= '0;
            a_q         <= '0;
            q_q         <= '0;
            qm1_q       <= 1'b0;
            cnt_q       <= '0;
            product_q   <= '0;
            overflow_q  <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            a_q         <= a_d;
            q_q         <= q_d;
            qm1_q       <= qm1_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            overflow_q  <= overflow_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign bus.ready     = (state_q == ST_IDLE);
    assign bus.product   = product_q;
    assign bus.overflow  = overflow_q;
    assign bus.valid_out = valid_out_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fixed_multiply_seq.sv
// Self-checking bench for fixed_multiply_seq: arithmetic reference model, per-cycle
// compare process with an expected queue, directed literals and random operands.
module tb_fixed_multiply_seq;
    import fixed_point_pkg::*;

    localparam int DW = 32;
    localparam int QB = 10;
    localparam int LAT = DW + 2;

    logic   clock;
    logic   reset;
    state_e dbg_state;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int acc_cyc = 0;
    bit busy = 0;
    logic [DW-1:0] last_p;
    logic          last_o;
    logic [DW-1:0] held_p;
    logic          held_o;
    logic [DW:0]   exp_q[$];

    fixed_multiply_seq_if #(.DATA_WIDTH(DW)) bus ();

    fixed_multiply_seq #(
        .QUANTIZED_BITS (QB),
        .DATA_WIDTH     (DW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Returns {overflow, product} from plain 64-bit signed arithmetic.
    function automatic logic [DW:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint p;
        longint r;
        logic   ovf;
        logic [DW-1:0] prod;
        p = longint'($signed(a)) * longint'($signed(b));
        r = (p + (longint'(1) <<< (QB - 1))) >>> QB;
        ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`ifdef FIXED_MULTIPLY_SAT_EN
        if (ovf) prod = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        else     prod = 32'(r);
`else
        prod = 32'(r);
`endif
        return {ovf, prod};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        logic exp_ready;
        logic exp_vo;
        logic [DW:0] e;
        #1;
        if (reset) begin
            busy   = 0;
            exp_q.delete();
            held_p = '0;
            held_o = 1'b0;
            chk("rst_ready", 64'(bus.ready), 64'd1);
            chk("rst_product", 64'(bus.product), 64'd0);
            chk("rst_overflow", 64'(bus.overflow), 64'd0);
            chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
        end else begin
            exp_ready = !(busy && (cyc < acc_cyc + LAT));
            exp_vo    = busy && (cyc == acc_cyc + LAT);
            chk("ready", 64'(bus.ready), 64'(exp_ready));
            chk("valid_out", 64'(bus.valid_out), 64'(exp_vo));
            if (bus.valid_out) begin
                done_cnt++;
                last_p = bus.product;
                last_o = bus.overflow;
            end
            if (exp_vo) begin
                busy = 0;
                if (exp_q.size() == 0) begin
                    chk("queue_empty", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    held_p = e[DW-1:0];
                    held_o = e[DW];
                end
            end
            chk("product", 64'(bus.product), 64'(held_p));
            chk("overflow", 64'(bus.overflow), 64'(held_o));
            if (bus.valid_in && exp_ready) begin
                exp_q.push_back(model(bus.multiplicand, bus.multiplier));
                busy    = 1;
                acc_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge clock);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.valid_in     = 1'b1;
        @(negedge clock);
        bus.valid_in     = 1'b0;
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
    endtask

    task automatic wait_done(input int c0);
        for (int i = 0; i < 60 && done_cnt == c0; i++) @(negedge clock);
        chk("done_timeout", 64'(done_cnt != c0), 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && busy; i++) @(negedge clock);
        chk("idle_timeout", 64'(busy), 64'd0);
        @(negedge clock);
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int c0;
        c0 = done_cnt;
        start_op(a, b);
        wait_done(c0);
    endtask

    task automatic run_lit(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] ep, input logic eo);
        run_op(a, b);
        chk(name, {31'd0, last_o, last_p}, {31'd0, eo, ep});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        repeat (40000) @(posedge clock);
        $display("FAIL watchdog: got timeout expected finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] a, b;
        logic [DW-1:0] sat_pos, sat_neg;
        int c0;
        reset = 1'b1;
        bus.valid_in = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Pin the model with hand-computed values.
        chk("model_basic", 64'(model(32'd1536, 32'd2048)), 64'h0_0000_0C00);
        chk("model_round_up", 64'(model(32'd23, 32'd23)), 64'h0_0000_0001);
        chk("model_round_neg", 64'(model(-32'sd23, 32'd23)), 64'h0_FFFF_FFFF);
`ifdef FIXED_MULTIPLY_SAT_EN
        sat_pos = 32'h7FFF_FFFF;
        sat_neg = 32'h8000_0000;
`else
        sat_pos = 32'h0000_0000;
        sat_neg = 32'h0000_0000;
`endif
        chk("model_ovf", 64'(model(32'd2097152, 32'd2097152)), {31'd0, 1'b1, sat_pos});

        // Directed literals.
        run_lit("basic", 32'd1536, 32'd2048, 32'd3072, 1'b0);
        run_lit("neg_pos", -32'sd1536, 32'd2048, -32'sd3072, 1'b0);
        run_lit("neg_neg", -32'sd512, -32'sd512, 32'd256, 1'b0);
        run_lit("min_x_one", 32'h8000_0000, 32'd1024, 32'h8000_0000, 1'b0);
        run_lit("round_23", 32'd23, 32'd23, 32'd1, 1'b0);
        run_lit("round_22", 32'd22, 32'd22, 32'd0, 1'b0);
        run_lit("round_m23", -32'sd23, 32'd23, 32'hFFFF_FFFF, 1'b0);
        run_lit("ovf_pos", 32'd2097152, 32'd2097152, sat_pos, 1'b1);
        run_lit("ovf_neg", -32'sd2097152, 32'd2097152, sat_neg, 1'b1);
        run_lit("zero", 32'd0, 32'h1234_5678, 32'd0, 1'b0);

        // Request during RUN is ignored.
        c0 = done_cnt;
        start_op(32'd1536, 32'd2048);
        repeat (5) @(negedge clock);
        bus.multiplicand = 32'd7777;
        bus.multiplier   = 32'd9999;
        bus.valid_in     = 1'b1;
        @(negedge clock);
        bus.valid_in     = 1'b0;
        wait_done(c0);
        chk("ignore_in_run", {32'd0, last_p}, 64'd3072);
        wait_idle();

        // valid_in held high: back-to-back results, operands changing every cycle.
        c0 = done_cnt;
        bus.valid_in = 1'b1;
        for (int i = 0; i < 110; i++) begin
            bus.multiplicand = {{16{1'b0}}, 16'($urandom)} - 32'd32768;
            bus.multiplier   = {{16{1'b0}}, 16'($urandom)} - 32'd32768;
            @(negedge clock);
        end
        bus.valid_in = 1'b0;
        wait_idle();
        chk("b2b_count", 64'(done_cnt - c0), 64'd4);

        // Reset in the middle of an operation.
        start_op(32'd1536, 32'd2048);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        c0 = done_cnt;
        repeat (40) @(negedge clock);
        chk("no_vo_after_rst", 64'(done_cnt), 64'(c0));
        run_lit("after_rst", -32'sd1536, 32'd2048, -32'sd3072, 1'b0);

        // Random operands of mixed magnitude.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 2))
                0: begin a = $urandom; b = $urandom; end
                1: begin
                    a = {{16{1'b0}}, 16'($urandom)} - 32'd32768;
                    b = $urandom;
                    b = {{12{b[19]}}, b[19:0]};
                end
                default: begin
                    a = 32'($urandom_range(0, 60)) - 32'd30;
                    b = 32'($urandom_range(0, 60)) - 32'd30;
                end
            endcase
            run_op(a, b);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
